// File: rtl/rv_decode_pkg.sv
// Shared opcodes, format codes and the decoded-instruction bundle carried through the
// decode pipeline. Bundle pc/imm are sized for RV64; RV32 builds use the low half.
package rv_decode_pkg;

    localparam int XLEN_MAX = 64;

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_REG32  = 7'b0111011;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_ILL = 3'd7
    } fmt_e;

    typedef struct packed {
        logic [XLEN_MAX-1:0] pc;
        logic [6:0]          opcode;
        logic [4:0]          rd;
        logic [2:0]          funct3;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [6:0]          funct7;
        logic [XLEN_MAX-1:0] imm;
        fmt_e                fmt;
        logic                illegal;
    } dec_bundle_t;

    // Only the base (0000000) and alternate (0100000) funct7 values exist for R-type.
    function automatic logic funct7_ok(input logic [6:0] funct7);
        return (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
    endfunction

endpackage

// File: rtl/rv_decode_pipe_imm_gen.sv
// Combinational format classifier and immediate generator for one 32-bit instruction.
// Immediates are sign-extended from instr[31] to XLEN; unknown encodings yield imm=0.
module rv_imm_gen
    import rv_decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output fmt_e            fmt,
    output logic            illegal
);

    localparam bit RV64 = (XLEN == 64);

    // Every supported opcode ends in 2'b11, so compressed-quadrant encodings fall to default.
    always_comb begin
        fmt = FMT_ILL;
        case (instr[6:0])
            OP_REG:                               fmt = FMT_R;
            OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM:  fmt = FMT_I;
            OP_STORE:                             fmt = FMT_S;
            OP_BRANCH:                            fmt = FMT_B;
            OP_LUI, OP_AUIPC:                     fmt = FMT_U;
            OP_JAL:                               fmt = FMT_J;
            OP_IMM32:                             fmt = RV64 ? FMT_I : FMT_ILL;
            OP_REG32:                             fmt = RV64 ? FMT_R : FMT_ILL;
            default:                              fmt = FMT_ILL;
        endcase
    end

    always_comb begin
        imm = '0;
        case (fmt)
            FMT_I: imm = XLEN'($signed(instr[31:20]));
            FMT_S: imm = XLEN'($signed({instr[31:25], instr[11:7]}));
            FMT_B: imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
            FMT_U: imm = XLEN'($signed({instr[31:12], 12'b0}));
            FMT_J: imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
            default: imm = '0;
        endcase
    end

    assign illegal = (fmt == FMT_ILL) || ((fmt == FMT_R) && !funct7_ok(instr[31:25]));

endmodule

// File: rtl/rv_decode_pipe.sv
// Pipelined RV32I/RV64I decode stage: decode is captured into stage 1, optional stage 2
// is a plain register copy, with valid/ready on both sides, flush, and a handshake counter.
module rv_decode_pipe
    import rv_decode_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int PIPE_STAGES = 1,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [6:0]       out_opcode,
    output logic [4:0]       out_rd,
    output logic [2:0]       out_funct3,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [6:0]       out_funct7,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [CNT_W-1:0] decode_count
);

    if ((PIPE_STAGES != 1) && (PIPE_STAGES != 2)) begin : g_bad_depth
        $error("rv_decode_pipe: PIPE_STAGES must be 1 or 2");
    end

    logic [XLEN-1:0] dec_imm;
    fmt_e            dec_fmt;
    logic            dec_illegal;
    dec_bundle_t     dec_in;

    rv_imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr   (in_instr),
        .imm     (dec_imm),
        .fmt     (dec_fmt),
        .illegal (dec_illegal)
    );

    always_comb begin
        dec_in         = '0;
        dec_in.pc      = XLEN_MAX'(in_pc);
        dec_in.opcode  = in_instr[6:0];
        dec_in.rd      = in_instr[11:7];
        dec_in.funct3  = in_instr[14:12];
        dec_in.rs1     = in_instr[19:15];
        dec_in.rs2     = in_instr[24:20];
        dec_in.funct7  = in_instr[31:25];
        dec_in.imm     = XLEN_MAX'($signed(dec_imm));
        dec_in.fmt     = dec_fmt;
        dec_in.illegal = dec_illegal;
    end

    logic [PIPE_STAGES-1:0] stage_valid_reg;
    dec_bundle_t            stage_data_reg [PIPE_STAGES];
    logic [PIPE_STAGES-1:0] stage_ready;
    logic [PIPE_STAGES-1:0] stage_in_valid;
    dec_bundle_t            stage_in_data  [PIPE_STAGES];

    for (genvar gi = 0; gi < PIPE_STAGES; gi++) begin : g_stage
        // Stage gi can take a new entry unless it and every stage after it are full
        // while the output is stalled; this is the unrolled !valid || ready_next chain.
        assign stage_ready[gi] = out_ready || !(&stage_valid_reg[PIPE_STAGES-1:gi]);

        if (gi == 0) begin : g_head
            assign stage_in_valid[gi] = in_valid;
            assign stage_in_data[gi]  = dec_in;
        end else begin : g_tail
            assign stage_in_valid[gi] = stage_valid_reg[gi-1];
            assign stage_in_data[gi]  = stage_data_reg[gi-1];
        end

        // Data only moves on a real transfer, which keeps a stalled output stable.
        always_ff @(posedge clk) begin
            if (rst) begin
                stage_valid_reg[gi] <= 1'b0;
                stage_data_reg[gi]  <= '0;
            end else if (flush) begin
                stage_valid_reg[gi] <= 1'b0;
            end else if (stage_ready[gi]) begin
                stage_valid_reg[gi] <= stage_in_valid[gi];
                if (stage_in_valid[gi]) begin
                    stage_data_reg[gi] <= stage_in_data[gi];
                end
            end
        end
    end

    dec_bundle_t out_bundle;
    assign out_bundle = stage_data_reg[PIPE_STAGES-1];

    if (XLEN < XLEN_MAX) begin : g_narrow
        // Upper halves of pc/imm only carry data in RV64 builds.
        logic unused_hi_bits;
        assign unused_hi_bits = ^{out_bundle.pc[XLEN_MAX-1:XLEN], out_bundle.imm[XLEN_MAX-1:XLEN]};
    end

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else if (out_valid && out_ready && !flush) begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

    assign in_ready     = stage_ready[0];
    assign out_valid    = stage_valid_reg[PIPE_STAGES-1];
    assign out_pc       = out_bundle.pc[XLEN-1:0];
    assign out_opcode   = out_bundle.opcode;
    assign out_rd       = out_bundle.rd;
    assign out_funct3   = out_bundle.funct3;
    assign out_rs1      = out_bundle.rs1;
    assign out_rs2      = out_bundle.rs2;
    assign out_funct7   = out_bundle.funct7;
    assign out_imm      = out_bundle.imm[XLEN-1:0];
    assign out_fmt      = out_bundle.fmt;
    assign out_illegal  = out_bundle.illegal;
    assign decode_count = count_reg;

endmodule

// File: tb/tb_rv_decode_pipe.sv
// Bench for rv_decode_pipe: a 1-stage and a 2-stage (4-bit counter) instance exercised in turn,
// checked against an arithmetic decode model and an in-order queue of accepted instructions.
module tb_rv_decode_pipe;

    logic        clk;
    logic        rst        [2];
    logic        flush      [2];
    logic        in_valid   [2];
    logic        in_ready   [2];
    logic [31:0] in_instr   [2];
    logic [31:0] in_pc      [2];
    logic        out_valid  [2];
    logic        out_ready  [2];
    logic [31:0] out_pc     [2];
    logic [6:0]  out_opcode [2];
    logic [4:0]  out_rd     [2];
    logic [2:0]  out_funct3 [2];
    logic [4:0]  out_rs1    [2];
    logic [4:0]  out_rs2    [2];
    logic [6:0]  out_funct7 [2];
    logic [31:0] out_imm    [2];
    logic [2:0]  out_fmt    [2];
    logic        out_illegal[2];
    logic [31:0] cnt_a;
    logic [3:0]  cnt_b;

    rv_decode_pipe #(.XLEN(32), .PIPE_STAGES(1), .CNT_W(32)) dut_a (
        .clk(clk), .rst(rst[0]), .flush(flush[0]),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_instr(in_instr[0]), .in_pc(in_pc[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_pc(out_pc[0]),
        .out_opcode(out_opcode[0]), .out_rd(out_rd[0]), .out_funct3(out_funct3[0]),
        .out_rs1(out_rs1[0]), .out_rs2(out_rs2[0]), .out_funct7(out_funct7[0]),
        .out_imm(out_imm[0]), .out_fmt(out_fmt[0]), .out_illegal(out_illegal[0]),
        .decode_count(cnt_a)
    );

    rv_decode_pipe #(.XLEN(32), .PIPE_STAGES(2), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst[1]), .flush(flush[1]),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_instr(in_instr[1]), .in_pc(in_pc[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_pc(out_pc[1]),
        .out_opcode(out_opcode[1]), .out_rd(out_rd[1]), .out_funct3(out_funct3[1]),
        .out_rs1(out_rs1[1]), .out_rs2(out_rs2[1]), .out_funct7(out_funct7[1]),
        .out_imm(out_imm[1]), .out_fmt(out_fmt[1]), .out_illegal(out_illegal[1]),
        .decode_count(cnt_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [2:0]  fmt;
        logic        ill;
        int          t;
    } exp_t;

    exp_t        q[$];
    int          cyc;
    logic [31:0] cnt_exp;
    int          n_checks;
    int          n_fail;

    logic [31:0] tv_instr [13];
    logic [2:0]  tv_fmt   [13];
    logic [31:0] tv_imm   [13];
    logic        tv_ill   [13];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Decode rules written as plain arithmetic on the field values.
    function automatic void ref_decode(input logic [31:0] i, output logic [2:0] f,
                                       output logic [31:0] imm, output logic ill);
        int v;
        f = 3'd7; imm = 32'd0; ill = 1'b1; v = 0;
        case (i[6:0])
            7'h33: begin
                f = 3'd0;
                ill = !((i[31:25] == 7'h00) || (i[31:25] == 7'h20));
            end
            7'h13, 7'h03, 7'h67, 7'h73: begin
                f = 3'd1; ill = 1'b0;
                v = int'(i[31:20]) - (i[31] ? 4096 : 0);
                imm = 32'(v);
            end
            7'h23: begin
                f = 3'd2; ill = 1'b0;
                v = int'({i[31:25], i[11:7]}) - (i[31] ? 4096 : 0);
                imm = 32'(v);
            end
            7'h63: begin
                f = 3'd3; ill = 1'b0;
                v = int'({i[31], i[7], i[30:25], i[11:8], 1'b0}) - (i[31] ? 8192 : 0);
                imm = 32'(v);
            end
            7'h37, 7'h17: begin
                f = 3'd4; ill = 1'b0;
                imm = {i[31:12], 12'h000};
            end
            7'h6f: begin
                f = 3'd5; ill = 1'b0;
                v = int'({i[31], i[19:12], i[20], i[30:21], 1'b0}) - (i[31] ? 2097152 : 0);
                imm = 32'(v);
            end
            default: ;
        endcase
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 13))
            0:  r[6:0] = 7'h33;
            1:  r[6:0] = 7'h13;
            2:  r[6:0] = 7'h03;
            3:  r[6:0] = 7'h67;
            4:  r[6:0] = 7'h73;
            5:  r[6:0] = 7'h23;
            6:  r[6:0] = 7'h63;
            7:  r[6:0] = 7'h37;
            8:  r[6:0] = 7'h17;
            9:  r[6:0] = 7'h6f;
            10: r[6:0] = 7'h1b;
            11: r[6:0] = 7'h3b;
            12: begin r[6:0] = 7'h33; r[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00; end
            default: ;
        endcase
        return r;
    endfunction

    // One clock: check outputs against the model, clock the DUT, then advance the model.
    task automatic step(input int d);
        logic        exp_valid, exp_ready, hs_in, hs_out, rst_s, flush_s;
        logic [31:0] instr_s, pc_s, cnt_obs, cnt_req;
        exp_t        e;
        #1;
        exp_valid = (q.size() > 0) && ((cyc - q[0].t) >= d);
        exp_ready = (q.size() < d + 1) || out_ready[d];
        cnt_obs   = (d == 0) ? cnt_a : {28'd0, cnt_b};
        cnt_req   = (d == 0) ? cnt_exp : (cnt_exp % 16);
        check("out_valid", out_valid[d], exp_valid);
        check("in_ready", in_ready[d], exp_ready);
        check("decode_count", cnt_obs, cnt_req);
        if (exp_valid) begin
            e = q[0];
            check("out_pc", out_pc[d], e.pc);
            check("out_opcode", out_opcode[d], e.instr[6:0]);
            check("out_rd", out_rd[d], e.instr[11:7]);
            check("out_funct3", out_funct3[d], e.instr[14:12]);
            check("out_rs1", out_rs1[d], e.instr[19:15]);
            check("out_rs2", out_rs2[d], e.instr[24:20]);
            check("out_funct7", out_funct7[d], e.instr[31:25]);
            check("out_imm", out_imm[d], e.imm);
            check("out_fmt", out_fmt[d], e.fmt);
            check("out_illegal", out_illegal[d], e.ill);
        end
        hs_in   = in_valid[d] && exp_ready;
        hs_out  = exp_valid && out_ready[d];
        rst_s   = rst[d];
        flush_s = flush[d];
        instr_s = in_instr[d];
        pc_s    = in_pc[d];
        @(posedge clk);
        cyc++;
        if (rst_s) begin
            q.delete();
            cnt_exp = 32'd0;
        end else if (flush_s) begin
            q.delete();
        end else begin
            if (hs_out) begin
                void'(q.pop_front());
                cnt_exp = cnt_exp + 32'd1;
            end
            if (hs_in) begin
                e.instr = instr_s;
                e.pc    = pc_s;
                ref_decode(instr_s, e.fmt, e.imm, e.ill);
                e.t     = cyc;
                q.push_back(e);
            end
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs(input int d);
        in_valid[d] = 1'b0; flush[d] = 1'b0; out_ready[d] = 1'b0;
        in_instr[d] = 32'd0; in_pc[d] = 32'd0;
    endtask

    task automatic reset_dut(input int d);
        idle_inputs(d);
        rst[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst[d] = 1'b0;
        q.delete();
        cnt_exp = 32'd0;
    endtask

    task automatic check_cleared(input int d);
        logic [31:0] cnt_obs;
        #1;
        cnt_obs = (d == 0) ? cnt_a : {28'd0, cnt_b};
        check("rst_out_valid", out_valid[d], 1'b0);
        check("rst_in_ready", in_ready[d], 1'b1);
        check("rst_count", cnt_obs, 32'd0);
        check("rst_pc", out_pc[d], 32'd0);
        check("rst_fields", {out_opcode[d], out_rd[d], out_funct3[d], out_rs1[d], out_rs2[d], out_funct7[d]}, 32'd0);
        check("rst_imm", out_imm[d], 32'd0);
        check("rst_fmt", out_fmt[d], 3'd0);
        check("rst_illegal", out_illegal[d], 1'b0);
    endtask

    task automatic rand_phase(input int d, input int n);
        for (int c = 0; c < n; c++) begin
            in_valid[d]  = ($urandom_range(0, 3) != 0);
            in_instr[d]  = rand_instr();
            in_pc[d]     = $urandom & 32'hFFFF_FFFC;
            out_ready[d] = ($urandom_range(0, 9) < 7);
            flush[d]     = ($urandom_range(0, 19) == 0);
            step(d);
        end
        flush[d] = 1'b0; in_valid[d] = 1'b0; out_ready[d] = 1'b1;
        for (int c = 0; c < 4; c++) step(d);
    endtask

    initial begin
        int          sent;
        logic        saw_block;
        logic [31:0] cnt_keep;
        n_checks = 0; n_fail = 0; cyc = 0; cnt_exp = 32'd0;
        for (int d = 0; d < 2; d++) begin
            idle_inputs(d);
            rst[d] = 1'b1;
        end
        tv_instr = '{32'h006100b3, 32'h00510093, 32'hfff00093, 32'h00208663, 32'h12345037,
                     32'h0200006f, 32'h00000000, 32'h406100b3, 32'h026100b3, 32'hfe112e23,
                     32'h0000001b, 32'h00510090, 32'hfe208ee3};
        tv_fmt   = '{3'd0, 3'd1, 3'd1, 3'd3, 3'd4, 3'd5, 3'd7, 3'd0, 3'd0, 3'd2, 3'd7, 3'd7, 3'd3};
        tv_imm   = '{32'h0, 32'h5, 32'hffffffff, 32'hc, 32'h12345000, 32'h20, 32'h0, 32'h0,
                     32'h0, 32'hfffffffc, 32'h0, 32'h0, 32'hfffffffc};
        tv_ill   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        @(negedge clk);

        // Single-stage instance: reset state, directed vectors back to back, random traffic.
        reset_dut(0);
        check_cleared(0);
        for (int k = 0; k < 13; k++) begin
            in_valid[0] = 1'b1; in_instr[0] = tv_instr[k]; in_pc[0] = 32'h1000 + 32'(4 * k);
            out_ready[0] = 1'b1;
            step(0);
            check("tv_valid", out_valid[0], 1'b1);
            check("tv_fmt", out_fmt[0], tv_fmt[k]);
            check("tv_imm", out_imm[0], tv_imm[k]);
            check("tv_illegal", out_illegal[0], tv_ill[k]);
        end
        in_valid[0] = 1'b0;
        step(0);
        step(0);
        rand_phase(0, 300);
        rst[0] = 1'b1;

        // Two-stage instance: stall window on cycles 3-6 with a 4-instruction stream.
        reset_dut(1);
        check_cleared(1);
        sent = 0; saw_block = 1'b0;
        for (int c = 0; c < 16; c++) begin
            in_valid[1]  = (sent < 4);
            in_instr[1]  = rand_instr();
            in_pc[1]     = 32'h2000 + 32'(4 * sent);
            out_ready[1] = !((c >= 3) && (c <= 6));
            #1;
            if (in_valid[1] && in_ready[1]) sent++;
            if (!in_ready[1]) saw_block = 1'b1;
            step(1);
        end
        check("stall_in_ready_fell", saw_block, 1'b1);
        check("stall_count", cnt_b, 4'd4);

        // Flush with both stages full and a new instruction offered in the same cycle.
        in_valid[1] = 1'b1; out_ready[1] = 1'b0;
        for (int c = 0; c < 2; c++) begin
            in_instr[1] = rand_instr(); in_pc[1] = 32'h3000 + 32'(4 * c);
            step(1);
        end
        check("flush_pre_valid", out_valid[1], 1'b1);
        cnt_keep = cnt_exp % 16;
        flush[1] = 1'b1; out_ready[1] = 1'b1; in_instr[1] = rand_instr();
        step(1);
        check("flush_out_valid", out_valid[1], 1'b0);
        check("flush_count", cnt_b, cnt_keep[3:0]);
        flush[1] = 1'b0; in_instr[1] = 32'h00510093; in_pc[1] = 32'h4000;
        step(1);
        in_valid[1] = 1'b0;
        check("flush_lat_early", out_valid[1], 1'b0);
        step(1);
        check("flush_lat_valid", out_valid[1], 1'b1);
        check("flush_lat_pc", out_pc[1], 32'h4000);
        step(1);

        rand_phase(1, 400);

        // Reset in the middle of a stalled stream.
        in_valid[1] = 1'b1; out_ready[1] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            in_instr[1] = rand_instr(); in_pc[1] = 32'h5000 + 32'(4 * c);
            step(1);
        end
        check("midrst_pre_valid", out_valid[1], 1'b1);
        rst[1] = 1'b1;
        step(1);
        rst[1] = 1'b0; in_valid[1] = 1'b0;
        check_cleared(1);
        step(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
